// File: rtl/melody_sequencer.sv
// Melody ROM sequencer: fetches note codes from an external synchronous ROM, holds each one for
// NOTE_TICKS cycles. Define MELODY_SEQUENCER_LOOP_EN to replay the melody until stopped.
module melody_sequencer #(
  parameter int unsigned NOTE_TICKS = 12500000,
  parameter int unsigned MELODY_LEN = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic [2:0] rom_addr,
  input  logic [1:0] rom_q,
  output logic [1:0] note,
  output logic       note_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StHold, StDone} state_e;

  localparam logic [23:0] TickLast = 24'(NOTE_TICKS - 1);
  localparam logic [2:0]  AddrLast = 3'(MELODY_LEN - 1);

  state_e      state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic [23:0] tick_q, tick_d;
  logic [1:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= 3'd0;
      tick_q  <= 24'd0;
      note_q  <= 2'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    note_d  = note_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    // stop overrides everything once playback is active
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      addr_d  = 3'd0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_d = StFetch;
            addr_d  = 3'd0;
          end
        end
        StFetch: state_d = StLatch;
        StLatch: begin
          note_d  = rom_q;
          valid_d = 1'b1;
          tick_d  = 24'd0;
          state_d = StHold;
        end
        StHold: begin
          if (tick_q == TickLast) begin
            if (addr_q == AddrLast) begin
              addr_d = 3'd0;
              done_d = 1'b1;
`ifdef MELODY_SEQUENCER_LOOP_EN
              state_d = StFetch;
`else
              state_d = StDone;
              valid_d = 1'b0;
`endif
            end else begin
              addr_d  = addr_q + 3'd1;
              state_d = StFetch;
            end
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign rom_addr   = addr_q;
  assign note       = note_q;
  assign note_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);

endmodule
